// File: rtl/kdw_tile_ctrl.sv
// Depthwise-kernel tile RAM sequencer: fills RAM_KDW from the weight stream, then replays it to the DW engine.
// Latency: load is 1 weight/cycle with ld_done one cycle after the last beat; replay gives the first element 2 cycles after rd_start.
// Backpressure: ld_ready is high for the whole load; on a replay stall the held address is re-read, so kw_data stays stable.
module kdw_tile_ctrl #(
   parameter int KDW_N_ELEM = 288,
   parameter int WG_W       = 8,
   parameter int K_SZ       = 9,
   parameter int AW         = $clog2(KDW_N_ELEM + 1),
   parameter int CW         = $clog2(KDW_N_ELEM / K_SZ + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_start,
   input  logic [CW-1:0]   n_ch,
   input  logic            ld_valid,
   input  logic [WG_W-1:0] ld_data,
   output logic            ld_ready,
   output logic            ld_done,
   output logic            cfg_err,
   input  logic            rd_start,
   output logic            kw_valid,
   output logic [WG_W-1:0] kw_data,
   output logic            kw_ch_last,
   output logic            kw_last,
   input  logic            kw_ready,
   output logic [AW-1:0]   ram_addr,
   output logic [WG_W-1:0] ram_data,
   output logic            ram_write,
   input  logic [WG_W-1:0] ram_res,
   output logic            busy,
   output logic            tile_valid
);

   // The n_ch range exceeds what fits in RAM, so the size check is done at a width
   // where n_ch*K_SZ cannot wrap; only a legal product is narrowed to AW.
   localparam int PW  = CW + $clog2(K_SZ + 1);
   localparam int KPW = (K_SZ > 1) ? $clog2(K_SZ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ} state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [AW-1:0]   r_n_elem;
   logic [AW-1:0]   r_wr_cnt;
   logic [AW-1:0]   r_rd_cnt;
   logic [AW-1:0]   r_out_cnt;
   logic [KPW-1:0]  r_rd_pos;     // r_rd_cnt modulo K_SZ
   logic [KPW-1:0]  r_out_pos;    // r_out_cnt modulo K_SZ
   logic            r_kw_valid;
   logic            r_tile_valid;
   logic            r_ld_done;
   logic            r_cfg_err;

   logic [PW-1:0]   w_req_elem;
   logic            w_cfg_bad;
   logic            w_ld_beat;
   logic            w_ld_final;
   logic            w_kw_stall;
   logic            w_kw_accept;
   logic            w_kw_final;
   logic            w_rd_issue;

   // Next state, stream handshakes and the RAM port, all decoded from the current state
   always_comb begin
      w_state_nxt = r_state;
      w_req_elem  = PW'(n_ch) * PW'(K_SZ);
      w_cfg_bad   = (n_ch == '0) || (w_req_elem > PW'(KDW_N_ELEM));
      w_ld_beat   = 1'b0;
      w_ld_final  = 1'b0;
      w_kw_stall  = 1'b0;
      w_kw_accept = 1'b0;
      w_kw_final  = 1'b0;
      w_rd_issue  = 1'b0;
      ld_ready    = 1'b0;
      ram_write   = 1'b0;
      ram_addr    = '0;
      ram_data    = '0;
      busy        = (r_state != S_IDLE);

      case (r_state)
         S_IDLE: begin
            // load_start has priority; rd_start in the same cycle is dropped
            if (load_start) begin
               if (!w_cfg_bad) w_state_nxt = S_LOAD;
            end else if (rd_start && r_tile_valid) begin
               w_state_nxt = S_READ;
            end
         end
         S_LOAD: begin
            ld_ready   = 1'b1;
            ram_write  = ld_valid;
            ram_addr   = r_wr_cnt;
            ram_data   = ld_data;
            w_ld_beat  = ld_valid;
            w_ld_final = ld_valid && (r_wr_cnt == r_n_elem - AW'(1));
            if (w_ld_final) w_state_nxt = S_IDLE;
         end
         S_READ: begin
            w_kw_stall  = r_kw_valid && !kw_ready;
            w_kw_accept = r_kw_valid && kw_ready;
            w_kw_final  = w_kw_accept && (r_out_cnt == r_n_elem - AW'(1));
            w_rd_issue  = (r_rd_cnt < r_n_elem) && (!r_kw_valid || kw_ready);
            // On a stall the held word is read again so ram_res does not move
            ram_addr    = w_kw_stall ? r_out_cnt : r_rd_cnt;
            if (w_kw_final) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Counters, output slot, tile status and the one-cycle status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n_elem     <= '0;
         r_wr_cnt     <= '0;
         r_rd_cnt     <= '0;
         r_out_cnt    <= '0;
         r_rd_pos     <= '0;
         r_out_pos    <= '0;
         r_kw_valid   <= 1'b0;
         r_tile_valid <= 1'b0;
         r_ld_done    <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_ld_done <= w_ld_final;
         r_cfg_err <= (r_state == S_IDLE) && load_start && w_cfg_bad;
         case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  if (!w_cfg_bad) begin
                     r_n_elem     <= AW'(w_req_elem);
                     r_wr_cnt     <= '0;
                     r_tile_valid <= 1'b0;
                  end
               end else if (rd_start && r_tile_valid) begin
                  r_rd_cnt   <= '0;
                  r_out_cnt  <= '0;
                  r_rd_pos   <= '0;
                  r_out_pos  <= '0;
                  r_kw_valid <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_ld_beat) begin
                  r_wr_cnt <= r_wr_cnt + AW'(1);
                  if (w_ld_final) r_tile_valid <= 1'b1;
               end
            end
            S_READ: begin
               // The word addressed now arrives on ram_res next cycle, so the slot is filled then
               if (w_rd_issue) begin
                  r_rd_cnt   <= r_rd_cnt + AW'(1);
                  r_rd_pos   <= (r_rd_pos == KPW'(K_SZ - 1)) ? '0 : r_rd_pos + KPW'(1);
                  r_out_cnt  <= r_rd_cnt;
                  r_out_pos  <= r_rd_pos;
                  r_kw_valid <= 1'b1;
               end else if (w_kw_accept) begin
                  r_kw_valid <= 1'b0;
               end
            end
            default: r_kw_valid <= 1'b0;
         endcase
      end
   end

   assign ld_done    = r_ld_done;
   assign cfg_err    = r_cfg_err;
   assign tile_valid = r_tile_valid;
   assign kw_valid   = r_kw_valid;
   assign kw_data    = r_kw_valid ? ram_res : '0;
   assign kw_ch_last = r_kw_valid && (r_out_pos == KPW'(K_SZ - 1));
   assign kw_last    = r_kw_valid && (r_out_cnt == r_n_elem - AW'(1));

endmodule
